// File: rtl/lsu_nbload_scoreboard_pkg.sv
// Shared types for the non-blocking load scoreboard.
// load_cam_pkt_t : one scoreboard entry {valid, wb, tag, rd}.
// nbload_state_e : decoded entry state (FREE / LIVE / STALE).
`ifndef RV_LSU_NUM_NBLOAD
`define RV_LSU_NUM_NBLOAD 4
`endif
`ifndef RV_LSU_NUM_NBLOAD_WIDTH
`define RV_LSU_NUM_NBLOAD_WIDTH 2
`endif

package swerv_types;

  localparam int unsigned NBLOAD_TAG_W = `RV_LSU_NUM_NBLOAD_WIDTH;

  typedef struct packed {
    logic                    valid;
    logic                    wb;
    logic [NBLOAD_TAG_W-1:0] tag;
    logic [4:0]              rd;
  } load_cam_pkt_t;

  typedef enum logic [1:0] {
    FREE,
    LIVE,
    STALE
  } nbload_state_e;

  function automatic nbload_state_e nbload_state(input load_cam_pkt_t e);
    if (!e.valid) return FREE;
    if (e.wb)     return STALE;
    return LIVE;
  endfunction

endpackage

// File: rtl/lsu_nbload_scoreboard_ffs.sv
// Find-first-zero encoder: picks the lowest-index free entry.
// busy       : per-entry valid bits.
// first_free : index of the lowest clear bit (0 when none is clear).
// any_free   : at least one bit is clear.
module lsu_nbload_ffs #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] busy,
  output logic [W-1:0] first_free,
  output logic         any_free
);

  always_comb begin
    first_free = '0;
    any_free   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!busy[i] && !any_free) begin
        first_free = W'(i);
        any_free   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_nbload_scoreboard.sv
// Outstanding non-blocking load scoreboard.
// Allocates a tag per issued load, tracks its destination register, marks
// entries stale when a younger write to the same register is seen, gates
// register-file writeback on data return and flags RAW hazards to decode.
// Ports:
//   alloc_valid/alloc_rd      : load issue;   alloc_ready/alloc_tag : grant
//   wb_valid/wb_tag/wb_error  : bus return
//   kill_valid/kill_rd        : younger register write
//   dep_rs1/dep_rs2 -> dep_hit: decode hazard query (combinational)
//   wb_rd_en/wb_rd/wb_err_o/spurious_wb : registered return pulses
//   busy_cnt                  : number of valid entries
`ifndef RV_LSU_NUM_NBLOAD
`define RV_LSU_NUM_NBLOAD 4
`endif
`ifndef RV_LSU_NUM_NBLOAD_WIDTH
`define RV_LSU_NUM_NBLOAD_WIDTH 2
`endif

module lsu_nbload_scoreboard
  import swerv_types::*;
#(
  parameter int unsigned NUM_NBLOAD = `RV_LSU_NUM_NBLOAD,
  parameter int unsigned TAG_W      = `RV_LSU_NUM_NBLOAD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             wb_error,
  input  logic             kill_valid,
  input  logic [4:0]       kill_rd,
  input  logic [4:0]       dep_rs1,
  input  logic [4:0]       dep_rs2,
  output logic             dep_hit,
  output logic             wb_rd_en,
  output logic [4:0]       wb_rd,
  output logic             wb_err_o,
  output logic             spurious_wb,
  output logic [TAG_W:0]   busy_cnt
);

  load_cam_pkt_t         cam_q [NUM_NBLOAD];
  load_cam_pkt_t         cam_d [NUM_NBLOAD];
  logic [NUM_NBLOAD-1:0] valid_vec;
  logic [NUM_NBLOAD-1:0] wb_match;
  logic [NUM_NBLOAD-1:0] kill_match;
  logic                  alloc_fire;
  logic                  kill_en;
  logic                  wb_hit;
  logic                  wb_live;
  logic [4:0]            wb_sel_rd;
  logic                  wb_kill;

  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < NUM_NBLOAD; i++) valid_vec[i] = cam_q[i].valid;
  end

  lsu_nbload_ffs #(
    .N(NUM_NBLOAD),
    .W(TAG_W)
  ) u_ffs (
    .busy      (valid_vec),
    .first_free(alloc_tag),
    .any_free  (alloc_ready)
  );

  assign alloc_fire = alloc_valid & alloc_ready;
  assign kill_en    = kill_valid & (kill_rd != 5'd0);

  always_comb begin
    wb_match   = '0;
    kill_match = '0;
    for (int unsigned i = 0; i < NUM_NBLOAD; i++) begin
      wb_match[i]   = wb_valid & cam_q[i].valid
                      & (cam_q[i].tag == NBLOAD_TAG_W'(wb_tag));
      kill_match[i] = kill_en & (cam_q[i].rd == kill_rd);
    end
  end

  // Alloc only targets FREE entries and wb/kill only act on valid ones, so
  // the three events never compete for the same entry except wb vs kill,
  // where the free wins.
  always_comb begin
    for (int unsigned i = 0; i < NUM_NBLOAD; i++) begin
      cam_d[i] = cam_q[i];
      case (nbload_state(cam_q[i]))
        FREE: begin
          if (alloc_fire && (alloc_tag == TAG_W'(i))) begin
            cam_d[i].valid = 1'b1;
            cam_d[i].wb    = (alloc_rd == 5'd0);
            cam_d[i].rd    = alloc_rd;
          end
        end
        LIVE: begin
          if (wb_match[i]) begin
            cam_d[i].valid = 1'b0;
            cam_d[i].wb    = 1'b0;
          end else if (kill_match[i]) begin
            cam_d[i].wb = 1'b1;
          end
        end
        STALE: begin
          if (wb_match[i]) begin
            cam_d[i].valid = 1'b0;
            cam_d[i].wb    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_hit    = 1'b0;
    wb_live   = 1'b0;
    wb_sel_rd = '0;
    for (int unsigned i = 0; i < NUM_NBLOAD; i++) begin
      if (wb_match[i]) begin
        wb_hit    = 1'b1;
        wb_live   = !cam_q[i].wb;
        wb_sel_rd = cam_q[i].rd;
      end
    end
  end

  assign wb_kill = kill_en & (kill_rd == wb_sel_rd);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NUM_NBLOAD; i++) begin
        cam_q[i].valid <= 1'b0;
        cam_q[i].wb    <= 1'b0;
        cam_q[i].tag   <= NBLOAD_TAG_W'(i);
        cam_q[i].rd    <= '0;
      end
      wb_rd_en    <= 1'b0;
      wb_rd       <= '0;
      wb_err_o    <= 1'b0;
      spurious_wb <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_NBLOAD; i++) cam_q[i] <= cam_d[i];
      wb_rd_en    <= wb_hit & wb_live & !wb_error & !wb_kill;
      wb_rd       <= wb_sel_rd;
      wb_err_o    <= wb_hit & wb_error;
      spurious_wb <= wb_valid & !wb_hit;
    end
  end

  always_comb begin
    dep_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_NBLOAD; i++) begin
      if ((nbload_state(cam_q[i]) == LIVE) &&
          (((dep_rs1 != 5'd0) && (cam_q[i].rd == dep_rs1)) ||
           ((dep_rs2 != 5'd0) && (cam_q[i].rd == dep_rs2))))
        dep_hit = 1'b1;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int unsigned i = 0; i < NUM_NBLOAD; i++)
      busy_cnt = busy_cnt + (TAG_W+1)'(cam_q[i].valid);
  end

endmodule

// File: tb/tb_lsu_nbload_scoreboard.sv
module tb_lsu_nbload_scoreboard;

  logic       clk;
  logic       rst_l;
  logic       alloc_valid;
  logic [4:0] alloc_rd;
  logic       alloc_ready;
  logic [1:0] alloc_tag;
  logic       wb_valid;
  logic [1:0] wb_tag;
  logic       wb_error;
  logic       kill_valid;
  logic [4:0] kill_rd;
  logic [4:0] dep_rs1;
  logic [4:0] dep_rs2;
  logic       dep_hit;
  logic       wb_rd_en;
  logic [4:0] wb_rd;
  logic       wb_err_o;
  logic       spurious_wb;
  logic [2:0] busy_cnt;

  typedef struct packed {
    logic       en;
    logic [4:0] rd;
    logic       err;
    logic       sp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  lsu_nbload_scoreboard #(
    .NUM_NBLOAD(4),
    .TAG_W     (2)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .alloc_valid(alloc_valid),
    .alloc_rd   (alloc_rd),
    .alloc_ready(alloc_ready),
    .alloc_tag  (alloc_tag),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_error   (wb_error),
    .kill_valid (kill_valid),
    .kill_rd    (kill_rd),
    .dep_rs1    (dep_rs1),
    .dep_rs2    (dep_rs2),
    .dep_hit    (dep_hit),
    .wb_rd_en   (wb_rd_en),
    .wb_rd      (wb_rd),
    .wb_err_o   (wb_err_o),
    .spurious_wb(spurious_wb),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    wb_error    = 1'b0;
    kill_valid  = 1'b0;
    kill_rd     = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [1:0] exp_tag);
    check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    step();
    clear();
  endtask

  task automatic ret(input logic [1:0] tag, input logic err, input exp_t e);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_error = err;
    q.push_back(e);
    step();
    clear();
  endtask

  task automatic kill(input logic [4:0] rd);
    kill_valid = 1'b1;
    kill_rd    = rd;
    step();
    clear();
  endtask

  task automatic dep(input logic [4:0] rs1, input logic [4:0] rs2, input logic exp);
    dep_rs1 = rs1;
    dep_rs2 = rs2;
    #1;
    check("dep_hit", 32'(dep_hit), 32'(exp));
  endtask

  task automatic busy(input int exp);
    check("busy_cnt", 32'(busy_cnt), 32'(exp));
  endtask

  // Monitor: every cycle after a return was presented, pop the expectation
  // and compare the registered pulses; in other cycles the pulses must be low.
  initial begin
    logic had;
    exp_t e;
    forever begin
      @(posedge clk);
      had = wb_valid;
      #1;
      if (had) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_queue: got return with no expectation queued");
        end else begin
          e = q.pop_front();
          check("mon_wb_rd_en", 32'(wb_rd_en), 32'(e.en));
          check("mon_wb_err_o", 32'(wb_err_o), 32'(e.err));
          check("mon_spurious", 32'(spurious_wb), 32'(e.sp));
          if (!e.sp) check("mon_wb_rd", 32'(wb_rd), 32'(e.rd));
        end
      end else begin
        check("mon_idle_pulse", {29'd0, wb_rd_en, wb_err_o, spurious_wb}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l   = 1'b1;
    dep_rs1 = '0;
    dep_rs2 = '0;
    clear();
    #1 rst_l = 1'b0;
    #2;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_dep_hit", 32'(dep_hit), 32'd0);
    check("rst_wb_rd_en", 32'(wb_rd_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_err_o", 32'(wb_err_o), 32'd0);
    check("rst_spurious", 32'(spurious_wb), 32'd0);
    busy(0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // Fill and drain
    alloc(5'd5, 2'd0);
    alloc(5'd6, 2'd1);
    alloc(5'd7, 2'd2);
    alloc(5'd8, 2'd3);
    check("full_ready", 32'(alloc_ready), 32'd0);
    busy(4);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    step();
    clear();
    check("full_ignore_ready", 32'(alloc_ready), 32'd0);
    busy(4);
    dep(5'd7, 5'd0, 1'b1);
    ret(2'd2, 1'b0, '{en: 1'b1, rd: 5'd7, err: 1'b0, sp: 1'b0});
    busy(3);
    check("freed_tag", 32'(alloc_tag), 32'd2);
    check("freed_ready", 32'(alloc_ready), 32'd1);
    // alloc of tag 2 alongside return of tag 0
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    wb_valid    = 1'b1;
    wb_tag      = 2'd0;
    q.push_back('{en: 1'b1, rd: 5'd5, err: 1'b0, sp: 1'b0});
    step();
    clear();
    busy(3);
    check("concurrent_tag", 32'(alloc_tag), 32'd0);
    ret(2'd1, 1'b0, '{en: 1'b1, rd: 5'd6, err: 1'b0, sp: 1'b0});
    ret(2'd2, 1'b0, '{en: 1'b1, rd: 5'd9, err: 1'b0, sp: 1'b0});
    ret(2'd3, 1'b0, '{en: 1'b1, rd: 5'd8, err: 1'b0, sp: 1'b0});
    busy(0);
    dep(5'd0, 5'd0, 1'b0);

    // Stale
    alloc(5'd10, 2'd0);
    kill(5'd10);
    dep(5'd10, 5'd0, 1'b0);
    busy(1);
    ret(2'd0, 1'b0, '{en: 1'b0, rd: 5'd10, err: 1'b0, sp: 1'b0});
    busy(0);

    // Same-cycle kill and alloc of the same rd
    alloc(5'd3, 2'd0);
    check("kill_alloc_tag", 32'(alloc_tag), 32'd1);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd3;
    kill_valid  = 1'b1;
    kill_rd     = 5'd3;
    step();
    clear();
    busy(2);
    dep(5'd3, 5'd0, 1'b1);
    ret(2'd0, 1'b0, '{en: 1'b0, rd: 5'd3, err: 1'b0, sp: 1'b0});
    ret(2'd1, 1'b0, '{en: 1'b1, rd: 5'd3, err: 1'b0, sp: 1'b0});
    busy(0);
    dep(5'd0, 5'd0, 1'b0);

    // Kill and return on the same entry in one cycle
    alloc(5'd4, 2'd0);
    wb_valid   = 1'b1;
    wb_tag     = 2'd0;
    kill_valid = 1'b1;
    kill_rd    = 5'd4;
    q.push_back('{en: 1'b0, rd: 5'd4, err: 1'b0, sp: 1'b0});
    step();
    clear();
    busy(0);
    check("kill_wb_tag", 32'(alloc_tag), 32'd0);

    // Dependency
    alloc(5'd12, 2'd0);
    dep(5'd0, 5'd12, 1'b1);
    alloc(5'd0, 2'd1);
    dep(5'd0, 5'd0, 1'b0);
    busy(2);
    dep(5'd12, 5'd0, 1'b1);
    kill(5'd12);
    dep(5'd0, 5'd12, 1'b0);
    ret(2'd0, 1'b0, '{en: 1'b0, rd: 5'd12, err: 1'b0, sp: 1'b0});
    ret(2'd1, 1'b0, '{en: 1'b0, rd: 5'd0, err: 1'b0, sp: 1'b0});
    busy(0);
    dep(5'd0, 5'd0, 1'b0);

    // Error and spurious returns
    alloc(5'd20, 2'd0);
    alloc(5'd21, 2'd1);
    ret(2'd1, 1'b1, '{en: 1'b0, rd: 5'd21, err: 1'b1, sp: 1'b0});
    busy(1);
    check("err_freed_tag", 32'(alloc_tag), 32'd1);
    ret(2'd3, 1'b0, '{en: 1'b0, rd: 5'd0, err: 1'b0, sp: 1'b1});
    busy(1);
    check("spur_tag", 32'(alloc_tag), 32'd1);
    ret(2'd0, 1'b0, '{en: 1'b1, rd: 5'd20, err: 1'b0, sp: 1'b0});
    busy(0);

    // Reset mid-flight
    alloc(5'd1, 2'd0);
    alloc(5'd2, 2'd1);
    alloc(5'd3, 2'd2);
    busy(3);
    dep(5'd2, 5'd0, 1'b1);
    #1 rst_l = 1'b0;
    #1;
    busy(0);
    check("mid_rst_ready", 32'(alloc_ready), 32'd1);
    check("mid_rst_tag", 32'(alloc_tag), 32'd0);
    check("mid_rst_dep", 32'(dep_hit), 32'd0);
    check("mid_rst_pulses", {28'd0, wb_rd_en, wb_err_o, spurious_wb, 1'b0}, 32'd0);
    check("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    @(posedge clk);
    #1 rst_l = 1'b1;
    ret(2'd0, 1'b0, '{en: 1'b0, rd: 5'd0, err: 1'b0, sp: 1'b1});
    busy(0);
    check("post_rst_tag", 32'(alloc_tag), 32'd0);

    step();
    step();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_nbload_scoreboard.md
# lsu_nbload_scoreboard

Tracks outstanding non-blocking loads between LSU issue and bus data return. Allocates a tag per load, records its destination register, and marks entries stale when a younger instruction overwrites the same register. Gates the register-file writeback on return and reports RAW hazards to decode for stall generation. Sits beside the LSU bus interface; entry state is held as `load_cam_pkt_t` from `swerv_types`.

## Interface
Parameters:
- `NUM_NBLOAD`, default `` `RV_LSU_NUM_NBLOAD `` (4): number of entries; power of two, 2..8.
- `TAG_W`, default `` `RV_LSU_NUM_NBLOAD_WIDTH `` (2): log2(NUM_NBLOAD).

Ports:
- `clk` in 1: core clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: LSU issues a non-blocking load this cycle.
- `alloc_rd` in 5: destination register of the load.
- `alloc_ready` out 1: at least one free entry.
- `alloc_tag` out TAG_W: tag granted to this cycle's allocation.
- `wb_valid` in 1: bus returns load data.
- `wb_tag` in TAG_W: tag of the returning load.
- `wb_error` in 1: the return carries a bus error.
- `kill_valid` in 1: a younger instruction writes `kill_rd` this cycle.
- `kill_rd` in 5: register being written.
- `dep_rs1`, `dep_rs2` in 5 each: decode source registers.
- `dep_hit` out 1: a source matches a live (non-stale) entry.
- `wb_rd_en` out 1: register-file write enable for load data.
- `wb_rd` out 5: register-file destination.
- `wb_err_o` out 1: a tagged return completed with error.
- `spurious_wb` out 1: a return arrived for a free tag.
- `busy_cnt` out TAG_W+1: number of valid entries.

## Operation
- Each entry is `{valid, wb, tag, rd}`. There are three states: FREE (`valid=0`), LIVE (`valid=1, wb=0`) and STALE (`valid=1, wb=1`).
- **Allocation:**
  - `alloc_tag` is the lowest-index FREE entry, computed from registered state.
  - `alloc_ready` is `|~valid`.
  - When `alloc_valid & alloc_ready`, the entry becomes LIVE with `rd=alloc_rd`.
  - If `alloc_rd==0`, the entry becomes STALE instead.
  - `alloc_valid` while `!alloc_ready` is a protocol violation. The block ignores it with no state change.
- **Kill:**
  - `kill_valid` sets `wb=1` on every LIVE entry whose `rd==kill_rd`.
  - Kill does not affect an entry being allocated in the same cycle, because the allocating load is younger than the writer.
  - `kill_rd==0` has no effect.
- **Writeback:**
  - `wb_valid` on a valid entry frees it at the next edge.
  - The registered outputs are `wb_rd_en = LIVE & !wb_error & !(kill_valid & kill_rd==rd)`, `wb_rd = rd`, and `wb_err_o = wb_error`.
  - `wb_valid` on a FREE tag changes no state, pulses `spurious_wb`, and leaves `wb_rd_en` at 0.
- **Dependency:**
  - `dep_hit` is asserted if any LIVE entry has `rd == dep_rs1` or `rd == dep_rs2`, with that rs nonzero.
  - `dep_hit` is combinational from registered state.
  - It excludes the allocation and kill happening in the current cycle.
- **Simultaneous events:**
  - A `wb` to tag T and an alloc in the same cycle never collide, because the alloc selects from the pre-edge FREE set. Tag T becomes allocatable on the next cycle.
  - Kill and wb to the same entry in the same cycle: the writeback is suppressed and the entry is freed.
  - Alloc, kill and wb in the same cycle are all applied independently per the rules above.
- `busy_cnt` is the registered popcount of `valid`.
- **Reset:** all entries FREE. `alloc_ready=1`, `alloc_tag=0`, `dep_hit=0`, `wb_rd_en=0`, `wb_rd=0`, `wb_err_o=0`, `spurious_wb=0`, `busy_cnt=0`. Reset mid-operation discards all outstanding entries, and later returns are reported as `spurious_wb`.

## Timing
- `alloc_tag`, `alloc_ready` and `dep_hit` are combinational from flops, with zero latency.
- A new entry is visible to `dep_hit` and `busy_cnt` one cycle after allocation.
- `wb_rd_en`, `wb_rd`, `wb_err_o` and `spurious_wb` are single-cycle pulses one cycle after `wb_valid`.
- A freed entry is reallocatable in the cycle after `wb_valid`.
- There is no combinational path from `alloc_valid`, `wb_*` or `kill_*` to any output.

## Structure
- Entry storage reuses `load_cam_pkt_t` from `swerv_types`. The `tag` field is constant per index.
- Add a `nbload_state_e` enum {FREE, LIVE, STALE} to `swerv_types` for debug and assertions.
- Use one sub-module, `lsu_nbload_ffs`: a parameterized find-first-zero encoder producing `alloc_tag` and `alloc_ready`.

## Test plan
- **Fill and drain:** allocate 4 loads with rd=5,6,7,8, expecting tags 0,1,2,3, then `alloc_ready=0` and `busy_cnt=4`. Return tag 2, expecting `wb_rd_en=1, wb_rd=7` the next cycle, after which `alloc_tag=2`.
- **Stale:** allocate rd=10 as tag 0, then `kill_rd=10`, then return tag 0. Expect `wb_rd_en=0` and `busy_cnt` back to 0.
- **Same-cycle kill and alloc:** while entry 0 (rd=3) is LIVE, issue `kill_rd=3` and an alloc with rd=3 together. Entry 0 becomes STALE and entry 1 is LIVE. A return on tag 1 gives `wb_rd_en=1, wb_rd=3`.
- **Dependency:** with a LIVE entry rd=12, `dep_rs2=12` gives `dep_hit=1`. `dep_rs1=0` with an alloc rd=0 entry gives `dep_hit=0`. After a kill on rd 12, `dep_hit=0`.
- **Error and spurious returns:** a return with `wb_error=1` on tag 1 gives `wb_err_o=1` and `wb_rd_en=0`, and frees the entry. A return on a FREE tag 3 gives `spurious_wb=1` with no state change.
- **Reset mid-flight:** with 3 entries LIVE, pulse `rst_l` low asynchronously. All outputs reach their reset values immediately, and a later return on tag 0 gives `spurious_wb=1`.
